// File: rtl/duck_motion_control.sv
// ---------------------------------------------------------------------------
// duck_motion_control
//
// Control FSM that sits directly upstream of the movement datapath. Once per
// frame tick it runs a player pass. Every BIRD_STEP_DIV frames it follows that
// with a bird pass. Each pass runs CLEAR, then at most one horizontal move,
// then at most one vertical move, then DRAW.
//
// CLEAR and DRAW each last a fixed number of cycles: 4 for a player pass and
// 16 for a bird pass. The datapath's registered `enable` flag is checked
// against that local timing.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   key_left / key_right / key_up / key_down
//              debounced active-high player direction keys
//   is_shot    level, the bird is hit this cycle
//   leave      datapath flag: the bird has exited or been reset to spawn
//   enable     datapath draw-complete flag (registered)
//   pause      (only with MOTION_PAUSE_EN) hold in HOLD and freeze escape
//   control    4-bit state code to the datapath (registered state)
//   PorB       0 = player pass, 1 = bird pass
//   fly        bird escape mode
//   fall       bird shot/falling mode
//   sync_err   sticky: enable was not 1 in the cycle after a dwell ended
//
// Optional feature macro: MOTION_PAUSE_EN (adds the `pause` input).
// ---------------------------------------------------------------------------
module duck_motion_control #(
  parameter int unsigned TICK_DIV      = 833333,
  parameter int unsigned BIRD_STEP_DIV = 2,
  parameter int unsigned DIR_HOLD      = 32,
  parameter int unsigned ESCAPE_STEPS  = 600,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       is_shot,
  input  logic       leave,
  input  logic       enable,
`ifdef MOTION_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] control,
  output logic       PorB,
  output logic       fly,
  output logic       fall,
  output logic       sync_err
);

  localparam int TICK_W  = (TICK_DIV > 1)      ? $clog2(TICK_DIV)          : 1;
  localparam int FRAME_W = (BIRD_STEP_DIV > 1) ? $clog2(BIRD_STEP_DIV)     : 1;
  localparam int DIR_W   = (DIR_HOLD > 1)      ? $clog2(DIR_HOLD)          : 1;
  localparam int ESC_W   = (ESCAPE_STEPS > 0)  ? $clog2(ESCAPE_STEPS + 1)  : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BIRD_STEP_DIV - 1);
  localparam logic [DIR_W-1:0]   DIR_LAST   = DIR_W'(DIR_HOLD - 1);
  localparam logic [ESC_W-1:0]   ESC_MAX    = ESC_W'(ESCAPE_STEPS);

  localparam logic [3:0] DWELL_PLAYER_LAST = 4'd3;
  localparam logic [3:0] DWELL_BIRD_LAST   = 4'd15;

  typedef enum logic [3:0] {
    PREHOLD = 4'b0100,
    HOLD    = 4'b0000,
    CLEAR   = 4'b0001,
    LEFT    = 4'b0011,
    RIGHT   = 4'b0010,
    DOWN    = 4'b0110,
    UP      = 4'b0111,
    DRAW    = 4'b0101
  } state_t;

  // Registered state
  state_t             state_reg, state_next;
  state_t             vert_reg, vert_next;    // vertical move latched at CLEAR exit (DRAW = none)
  logic               porb_reg, porb_next;
  logic [3:0]         dwell_reg, dwell_next;
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [7:0]         lfsr_reg;
  logic               dx_reg, dx_next;
  logic               dy_reg, dy_next;
  logic [DIR_W-1:0]   dir_cnt_reg, dir_cnt_next;
  logic [ESC_W-1:0]   esc_cnt_reg, esc_cnt_next;
  logic               fly_reg, fly_next;
  logic               fall_reg, fall_next;
  logic               sync_err_reg;
  logic               dwell_done_reg;         // first cycle after any dwell ended
  logic               bird_done_reg;          // first cycle after a bird DRAW dwell ended

  // Combinational helpers
  logic   tick;
  logic   pause_act;
  logic   dwell_last;
  logic   dwell_end;
  logic   bird_pass_end;
  logic   normal_mode;
  logic   h_valid;
  state_t h_move;
  state_t v_move;

`ifdef MOTION_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  assign tick        = (tick_cnt_reg == TICK_LAST);
  assign normal_mode = ~fly_reg & ~fall_reg;
  assign dwell_last  = (dwell_reg == (porb_reg ? DWELL_BIRD_LAST : DWELL_PLAYER_LAST));

  // Move selection, consumed on the CLEAR exit cycle
  always_comb begin
    h_valid = 1'b0;
    h_move  = RIGHT;
    v_move  = DRAW;
    if (!porb_reg) begin
      // Opposing keys cancel; exactly one key of a pair gives a move
      h_valid = key_left ^ key_right;
      h_move  = key_left ? LEFT : RIGHT;
      if (key_up & ~key_down) begin
        v_move = UP;
      end else if (key_down & ~key_up) begin
        v_move = DOWN;
      end
    end else if (fall_reg) begin
      v_move = DOWN;
    end else if (fly_reg) begin
      v_move = UP;
    end else begin
      h_valid = 1'b1;
      h_move  = dx_reg ? RIGHT : LEFT;
      v_move  = dy_reg ? DOWN : UP;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    vert_next      = vert_reg;
    porb_next      = porb_reg;
    dwell_next     = 4'd0;
    frame_cnt_next = frame_cnt_reg;
    dwell_end      = 1'b0;
    bird_pass_end  = 1'b0;
    case (state_reg)
      PREHOLD: begin
        state_next = CLEAR;
        porb_next  = 1'b0;
      end
      HOLD: begin
        // Ticks seen outside HOLD are simply lost, so passes never queue
        if (tick && !pause_act) begin
          state_next = CLEAR;
          porb_next  = 1'b0;
        end
      end
      CLEAR: begin
        if (dwell_last) begin
          dwell_end  = 1'b1;
          vert_next  = v_move;
          state_next = h_valid ? h_move : v_move;
        end else begin
          dwell_next = dwell_reg + 4'd1;
        end
      end
      LEFT, RIGHT: state_next = vert_reg;
      UP, DOWN:    state_next = DRAW;
      DRAW: begin
        if (dwell_last) begin
          dwell_end = 1'b1;
          if (!porb_reg) begin
            if (frame_cnt_reg == FRAME_LAST) begin
              porb_next      = 1'b1;
              state_next     = CLEAR;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt_reg + 1'b1;
              state_next     = HOLD;
            end
          end else begin
            bird_pass_end = 1'b1;
            porb_next     = 1'b0;
            state_next    = HOLD;
          end
        end else begin
          dwell_next = dwell_reg + 4'd1;
        end
      end
      default: state_next = PREHOLD;
    endcase
  end

  // Bird mode, escape and direction bookkeeping
  always_comb begin
    fly_next     = fly_reg;
    fall_next    = fall_reg;
    esc_cnt_next = esc_cnt_reg;
    dir_cnt_next = dir_cnt_reg;
    dx_next      = dx_reg;
    dy_next      = dy_reg;
    if (bird_pass_end && normal_mode) begin
      if (!pause_act && (esc_cnt_reg != ESC_MAX)) begin
        esc_cnt_next = esc_cnt_reg + 1'b1;
      end
      if (esc_cnt_next == ESC_MAX) begin
        fly_next = 1'b1;
      end
      if (dir_cnt_reg == DIR_LAST) begin
        dir_cnt_next = '0;
        dx_next      = lfsr_reg[1];
        dy_next      = lfsr_reg[0];
      end else begin
        dir_cnt_next = dir_cnt_reg + 1'b1;
      end
    end
    // A hit overrides an escape that saturates in the same cycle
    if (is_shot && normal_mode) begin
      fall_next = 1'b1;
      fly_next  = 1'b0;
    end
    if (bird_done_reg && leave) begin
      fly_next     = 1'b0;
      fall_next    = 1'b0;
      esc_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= PREHOLD;
      vert_reg       <= DRAW;
      porb_reg       <= 1'b0;
      dwell_reg      <= 4'd0;
      frame_cnt_reg  <= '0;
      tick_cnt_reg   <= '0;
      lfsr_reg       <= LFSR_SEED;
      dx_reg         <= 1'b1;
      dy_reg         <= 1'b1;
      dir_cnt_reg    <= '0;
      esc_cnt_reg    <= '0;
      fly_reg        <= 1'b0;
      fall_reg       <= 1'b0;
      sync_err_reg   <= 1'b0;
      dwell_done_reg <= 1'b0;
      bird_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      vert_reg       <= vert_next;
      porb_reg       <= porb_next;
      dwell_reg      <= dwell_next;
      frame_cnt_reg  <= frame_cnt_next;
      tick_cnt_reg   <= tick ? '0 : tick_cnt_reg + 1'b1;
      if (tick) begin
        // x^8 + x^6 + x^5 + x^4 + 1, shifting left
        lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      end
      dx_reg         <= dx_next;
      dy_reg         <= dy_next;
      dir_cnt_reg    <= dir_cnt_next;
      esc_cnt_reg    <= esc_cnt_next;
      fly_reg        <= fly_next;
      fall_reg       <= fall_next;
      dwell_done_reg <= dwell_end;
      bird_done_reg  <= bird_pass_end;
      if (dwell_done_reg && !enable) begin
        sync_err_reg <= 1'b1;
      end
    end
  end

  assign control  = state_reg;
  assign PorB     = porb_reg;
  assign fly      = fly_reg;
  assign fall     = fall_reg;
  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_duck_motion_control.sv
// ---------------------------------------------------------------------------
// tb_duck_motion_control
//
// Directed bench for duck_motion_control. Each table record describes one
// pass: the key/shot/leave stimulus plus the expected pass shape (PorB, move
// states, CLEAR/DRAW lengths) and the fly/fall/sync_err values at the start
// of that pass. A short hand-written sequence at the end covers the sticky
// sync_err flag and the asynchronous reset.
// ---------------------------------------------------------------------------
module tb_duck_motion_control;

  localparam logic [3:0] S_PREHOLD = 4'b0100;
  localparam logic [3:0] S_HOLD    = 4'b0000;
  localparam logic [3:0] S_CLEAR   = 4'b0001;
  localparam logic [3:0] S_LEFT    = 4'b0011;
  localparam logic [3:0] S_RIGHT   = 4'b0010;
  localparam logic [3:0] S_DOWN    = 4'b0110;
  localparam logic [3:0] S_UP      = 4'b0111;
  localparam logic [3:0] S_DRAW    = 4'b0101;
  localparam logic [3:0] S_NONE    = 4'hF;
  localparam int         NVEC      = 27;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_left, key_right, key_up, key_down;
  logic       is_shot, leave, enable;
  logic [3:0] control;
  logic       PorB, fly, fall, sync_err;

  always #5 clk = ~clk;

  duck_motion_control #(
    .TICK_DIV     (10),
    .BIRD_STEP_DIV(2),
    .DIR_HOLD     (32),
    .ESCAPE_STEPS (3),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .key_left (key_left),
    .key_right(key_right),
    .key_up   (key_up),
    .key_down (key_down),
    .is_shot  (is_shot),
    .leave    (leave),
    .enable   (enable),
`ifdef MOTION_PAUSE_EN
    .pause    (1'b0),
`endif
    .control  (control),
    .PorB     (PorB),
    .fly      (fly),
    .fall     (fall),
    .sync_err (sync_err)
  );

  typedef struct {
    logic       kl, kr, ku, kd;
    logic       shot, lv;
    logic       porb;
    logic [3:0] h, v;
    int         clr, drw;
    logic       fly, fall;
  } vec_t;

  vec_t vecs[NVEC];

  int tests_run    = 0;
  int tests_failed = 0;

  // Captured pass shape
  logic       c_porb, c_fly, c_fall, c_serr, c_timeout, c_bad;
  logic [3:0] c_h, c_v;
  int         c_clr, c_drw;
  int         prehold_cycles;
  int         guard;

  function automatic vec_t mk(input logic kl, input logic kr, input logic ku, input logic kd,
                              input logic shot, input logic lv, input logic porb,
                              input logic [3:0] h, input logic [3:0] v,
                              input logic fl, input logic fa);
    vec_t r;
    r.kl = kl; r.kr = kr; r.ku = ku; r.kd = kd;
    r.shot = shot; r.lv = lv; r.porb = porb;
    r.h = h; r.v = v;
    r.clr = porb ? 16 : 4;
    r.drw = porb ? 16 : 4;
    r.fly = fl; r.fall = fa;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    is_shot = 1'b0;
  endtask

  // Follows one pass from its first CLEAR cycle to the end of its DRAW dwell
  task automatic capture(output logic porb_s, output logic fly_s, output logic fall_s,
                         output logic serr_s, output logic timed_out, output logic bad_order,
                         output logic [3:0] h, output logic [3:0] v,
                         output int clr, output int drw);
    int g;
    g = 0;
    bad_order = 1'b0;
    h = S_NONE;
    v = S_NONE;
    clr = 0;
    drw = 0;
    while (control != S_CLEAR && g < 300) begin
      step();
      g++;
    end
    timed_out = (control != S_CLEAR);
    porb_s = PorB;
    fly_s  = fly;
    fall_s = fall;
    serr_s = sync_err;
    while (control == S_CLEAR && clr < 100) begin
      clr++;
      step();
    end
    g = 0;
    while ((control == S_LEFT || control == S_RIGHT || control == S_UP || control == S_DOWN) && g < 10) begin
      g++;
      if (control == S_LEFT || control == S_RIGHT) begin
        if (h == S_NONE && v == S_NONE) h = control;
        else bad_order = 1'b1;
      end else begin
        if (v == S_NONE) v = control;
        else bad_order = 1'b1;
      end
      step();
    end
    while (control == S_DRAW && drw < 100) begin
      drw++;
      step();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //              kl kr ku kd sh lv pb  h        v        fly fall
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, S_NONE,  S_NONE,  0, 0); // initial clear pass
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, S_RIGHT, S_NONE,  0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // bird, esc=1
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, S_NONE,  S_NONE,  0, 0); // opposing keys cancel
    vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, S_NONE,  S_UP,    0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // bird, esc=2
    vecs[6]  = mk(1, 0, 0, 1, 0, 0, 0, S_LEFT,  S_DOWN,  0, 0);
    vecs[7]  = mk(0, 0, 1, 1, 1, 0, 0, S_NONE,  S_NONE,  0, 1); // shot before pass
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, S_NONE,  S_DOWN,  0, 1); // falling bird, leave
    vecs[9]  = mk(0, 1, 1, 0, 0, 1, 0, S_RIGHT, S_UP,    0, 0); // fall cleared
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, S_LEFT,  S_NONE,  0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // esc=1 again
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, S_NONE,  S_DOWN,  0, 0);
    vecs[13] = mk(1, 1, 1, 0, 0, 0, 0, S_NONE,  S_UP,    0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // esc=2
    vecs[15] = mk(0, 1, 0, 1, 0, 0, 0, S_RIGHT, S_DOWN,  0, 0);
    vecs[16] = mk(1, 1, 1, 1, 0, 0, 0, S_NONE,  S_NONE,  0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // esc=3 -> fly
    vecs[18] = mk(0, 0, 0, 0, 1, 0, 0, S_NONE,  S_NONE,  1, 0); // shot ignored in fly
    vecs[19] = mk(1, 0, 1, 0, 0, 0, 0, S_LEFT,  S_UP,    1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, S_NONE,  S_UP,    1, 0); // flying bird
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, S_NONE,  S_NONE,  1, 0);
    vecs[22] = mk(0, 1, 0, 0, 0, 0, 0, S_RIGHT, S_NONE,  1, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 1, S_NONE,  S_UP,    1, 0); // leave clears fly
    vecs[24] = mk(0, 0, 0, 0, 0, 1, 0, S_NONE,  S_NONE,  0, 0);
    vecs[25] = mk(0, 0, 1, 0, 0, 0, 0, S_NONE,  S_UP,    0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 1, S_RIGHT, S_DOWN,  0, 0); // normal again

    reset_n = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    is_shot = 1'b0; leave = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_control",  32'(control),  32'(S_PREHOLD));
    check("reset_porb",     32'(PorB),     32'd0);
    check("reset_fly",      32'(fly),      32'd0);
    check("reset_fall",     32'(fall),     32'd0);
    check("reset_sync_err", 32'(sync_err), 32'd0);

    reset_n = 1'b1;
    prehold_cycles = 0;
    while (control == S_PREHOLD && prehold_cycles < 10) begin
      prehold_cycles++;
      step();
    end
    check("prehold_cycles", 32'(prehold_cycles), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      key_left  = vecs[i].kl;
      key_right = vecs[i].kr;
      key_up    = vecs[i].ku;
      key_down  = vecs[i].kd;
      leave     = vecs[i].lv;
      is_shot   = vecs[i].shot;
      capture(c_porb, c_fly, c_fall, c_serr, c_timeout, c_bad, c_h, c_v, c_clr, c_drw);
      check($sformatf("v%0d_timeout", i),  32'(c_timeout), 32'd0);
      check($sformatf("v%0d_porb", i),     32'(c_porb),    32'(vecs[i].porb));
      check($sformatf("v%0d_clear", i),    32'(c_clr),     32'(vecs[i].clr));
      check($sformatf("v%0d_horiz", i),    32'(c_h),       32'(vecs[i].h));
      check($sformatf("v%0d_vert", i),     32'(c_v),       32'(vecs[i].v));
      check($sformatf("v%0d_order", i),    32'(c_bad),     32'd0);
      check($sformatf("v%0d_draw", i),     32'(c_drw),     32'(vecs[i].drw));
      check($sformatf("v%0d_fly", i),      32'(c_fly),     32'(vecs[i].fly));
      check($sformatf("v%0d_fall", i),     32'(c_fall),    32'(vecs[i].fall));
      check($sformatf("v%0d_sync_err", i), 32'(c_serr),    32'd0);
      $display("[TB] pass %0d: PorB=%0d clear=%0d h=%0h v=%0h draw=%0d fly=%0d fall=%0d",
               i, c_porb, c_clr, c_h, c_v, c_drw, c_fly, c_fall);
    end

    // enable stuck low: sync_err rises after the first dwell and stays set
    reset_n = 1'b0;
    enable = 1'b0;
    key_left = 1'b0; key_right = 1'b0; key_up = 1'b0; key_down = 1'b0;
    leave = 1'b0;
    repeat (2) @(negedge clk);
    check("serr_reset_control", 32'(control), 32'(S_PREHOLD));
    reset_n = 1'b1;
    guard = 0;
    while (control != S_DRAW && guard < 50) begin
      step();
      guard++;
    end
    check("serr_draw_reached", 32'(control == S_DRAW), 32'd1);
    check("serr_before", 32'(sync_err), 32'd0);
    step();
    check("serr_set", 32'(sync_err), 32'd1);
    repeat (40) step();
    check("serr_sticky", 32'(sync_err), 32'd1);
    $display("[TB] sync_err sequence: sync_err=%0d after 40 cycles", sync_err);

    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_sync_err", 32'(sync_err), 32'd0);
    check("async_reset_control",  32'(control),  32'(S_PREHOLD));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
